// File: rtl/dft_pkg.sv
// Shared constants and types for the sliding-DFT read side.
package dft_pkg;

    localparam int DFT_WIDTH   = 12;
    localparam int DFT_BIN_NUM = 128;

    typedef struct packed {
        logic signed [DFT_WIDTH-1:0] re;
        logic signed [DFT_WIDTH-1:0] im;
    } bin_t;

    typedef enum logic [1:0] {IDLE, READ, DRAIN} rd_state_t;

    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int ADDR_W = addr_w(DFT_BIN_NUM);

endpackage

// File: rtl/dft_bin_reader_bin_out_fifo.sv
// Synchronous FIFO for the bin output stream; the head entry is presented straight from storage.
module bin_out_fifo import dft_pkg::*; #(
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_push,
    input  logic [DW-1:0]          i_data,
    input  logic                   i_pop,
    output logic [DW-1:0]          o_data,
    output logic                   o_valid,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int PW = $clog2(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;
    logic          w_pop;

    assign w_pop = i_pop && (r_count != '0);

    // The writer never pushes into a full FIFO unless a pop happens in the same cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_valid = (r_count != '0);
    assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;
    assign o_count = r_count;

endmodule

// File: rtl/dft_bin_reader.sv
// Walks the DFT bin memory on each done edge and streams bins out over valid/ready.
// Optional macro DFT_BIN_MAGSQ_EN adds o_magsq = re^2 + im^2 alongside each beat.
module dft_bin_reader import dft_pkg::*; #(
    parameter int WIDTH      = DFT_WIDTH,
    parameter int BIN_NUM    = DFT_BIN_NUM,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       i_sys_clk,
    input  logic                       i_sys_rst,
    input  logic                       i_done,
    output logic                       o_rd_en,
    output logic [$clog2(BIN_NUM)-1:0] o_bin_addr,
    input  logic signed [WIDTH-1:0]    i_bin_re,
    input  logic signed [WIDTH-1:0]    i_bin_im,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic signed [WIDTH-1:0]    o_re,
    output logic signed [WIDTH-1:0]    o_im,
    output logic [$clog2(BIN_NUM)-1:0] o_idx,
    output logic                       o_last,
`ifdef DFT_BIN_MAGSQ_EN
    output logic [2*WIDTH-1:0]         o_magsq,
`endif
    output logic                       o_busy,
    output logic                       o_overrun
);

    localparam int AW = addr_w(BIN_NUM);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
`ifdef DFT_BIN_MAGSQ_EN
    localparam int MW = 2*WIDTH;
`else
    localparam int MW = 0;
`endif
    localparam int DW = AW + 1 + 2*WIDTH + MW;
    localparam logic [AW-1:0] LAST_ADDR = AW'(BIN_NUM-1);

    rd_state_t     r_state;
    rd_state_t     w_state_nxt;
    logic          r_done_q;
    logic          w_start;
    logic [AW-1:0] r_addr;
    logic [AW-1:0] r_cap_addr;
    logic          r_inflight;
    logic          r_overrun;
    logic [CW-1:0] w_count;
    logic          w_room;
    logic          w_fifo_valid;
    logic          w_pop;
    logic [DW-1:0] w_wr_data;
    logic [DW-1:0] w_rd_data;

    assign w_start = i_done & ~r_done_q;
    // Counting the read still in flight guarantees every returning word has a free slot.
    assign w_room  = (w_count + CW'(r_inflight)) < CW'(FIFO_DEPTH);

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) r_state <= IDLE;
        else           r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_start) w_state_nxt = READ;
            READ:    if (o_rd_en && (r_addr == LAST_ADDR)) w_state_nxt = DRAIN;
            DRAIN:   if (!w_fifo_valid && !r_inflight) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_rd_en = (r_state == READ) && w_room;
        o_busy  = (r_state != IDLE);
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            r_done_q   <= 1'b0;
            r_addr     <= '0;
            r_cap_addr <= '0;
            r_inflight <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_done_q   <= i_done;
            r_inflight <= o_rd_en;
            r_cap_addr <= r_addr;
            if (w_start && (r_state != IDLE)) r_overrun <= 1'b1;
            if (r_state == IDLE)
                r_addr <= '0;
            else if (o_rd_en && (r_addr != LAST_ADDR))
                r_addr <= r_addr + 1'b1;
        end
    end

`ifdef DFT_BIN_MAGSQ_EN
    localparam logic [WIDTH-1:0] S_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    logic signed [2*WIDTH-1:0] w_re_ext;
    logic signed [2*WIDTH-1:0] w_im_ext;
    logic signed [2*WIDTH-1:0] w_re_sq;
    logic signed [2*WIDTH-1:0] w_im_sq;
    logic [2*WIDTH-1:0]        w_magsq;

    assign w_re_ext = {{WIDTH{i_bin_re[WIDTH-1]}}, i_bin_re};
    assign w_im_ext = {{WIDTH{i_bin_im[WIDTH-1]}}, i_bin_im};
    assign w_re_sq  = w_re_ext * w_re_ext;
    assign w_im_sq  = w_im_ext * w_im_ext;
    // Only both-components-at-minimum reaches 2^(2W-1); it is clamped to all-ones.
    assign w_magsq  = ((i_bin_re == S_MIN) && (i_bin_im == S_MIN)) ? '1
                    : ($unsigned(w_re_sq) + $unsigned(w_im_sq));
    assign w_wr_data = {r_cap_addr, (r_cap_addr == LAST_ADDR), i_bin_re, i_bin_im, w_magsq};
    assign {o_idx, o_last, o_re, o_im, o_magsq} = w_rd_data;
`else
    assign w_wr_data = {r_cap_addr, (r_cap_addr == LAST_ADDR), i_bin_re, i_bin_im};
    assign {o_idx, o_last, o_re, o_im} = w_rd_data;
`endif

    assign w_pop     = w_fifo_valid & i_ready;
    assign o_valid   = w_fifo_valid;
    assign o_bin_addr = r_addr;
    assign o_overrun = r_overrun;

    bin_out_fifo #(
        .DW    (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_sys_clk),
        .i_rst   (i_sys_rst),
        .i_push  (r_inflight),
        .i_data  (w_wr_data),
        .i_pop   (w_pop),
        .o_data  (w_rd_data),
        .o_valid (w_fifo_valid),
        .o_count (w_count)
    );

endmodule

// File: tb/tb_dft_bin_reader.sv
// Bench for dft_bin_reader: bin-memory model, per-cycle stream scoreboard and directed scenarios.
module tb_dft_bin_reader;

    localparam int WIDTH      = 12;
    localparam int BIN_NUM    = 128;
    localparam int FIFO_DEPTH = 4;
    localparam int AW         = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    rst   = 1'b1;
    logic                    done  = 1'b0;
    logic                    ready = 1'b0;
    logic                    rd_en;
    logic [AW-1:0]           bin_addr;
    logic signed [WIDTH-1:0] bin_re = '0;
    logic signed [WIDTH-1:0] bin_im = '0;
    logic                    valid;
    logic signed [WIDTH-1:0] re;
    logic signed [WIDTH-1:0] im;
    logic [AW-1:0]           idx;
    logic                    last;
    logic                    busy;
    logic                    overrun;
`ifdef DFT_BIN_MAGSQ_EN
    logic [2*WIDTH-1:0]      magsq;
    logic [2*WIDTH-1:0]      p_mag;
    longint                  got_mag [BIN_NUM];
`endif

    dft_bin_reader #(.WIDTH(WIDTH), .BIN_NUM(BIN_NUM), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .i_sys_clk  (clk),
        .i_sys_rst  (rst),
        .i_done     (done),
        .o_rd_en    (rd_en),
        .o_bin_addr (bin_addr),
        .i_bin_re   (bin_re),
        .i_bin_im   (bin_im),
        .o_valid    (valid),
        .i_ready    (ready),
        .o_re       (re),
        .o_im       (im),
        .o_idx      (idx),
        .o_last     (last),
`ifdef DFT_BIN_MAGSQ_EN
        .o_magsq    (magsq),
`endif
        .o_busy     (busy),
        .o_overrun  (overrun)
    );

    int tests = 0;
    int fails = 0;
    int mem_re [BIN_NUM];
    int mem_im [BIN_NUM];
    int got_re [BIN_NUM];
    int got_im [BIN_NUM];

    // Bin memory: one-cycle read latency.
    always @(posedge clk) begin
        if (rd_en) begin
            bin_re <= WIDTH'(mem_re[bin_addr]);
            bin_im <= WIDTH'(mem_im[bin_addr]);
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    function automatic longint exp_magsq(input int r, input int i);
        if (r == -(1 << (WIDTH-1)) && i == -(1 << (WIDTH-1)))
            return (longint'(1) << (2*WIDTH)) - 1;
        return longint'(r) * r + longint'(i) * i;
    endfunction

    // Stream model: beats arrive in index order, outstanding reads never exceed the buffer.
    int                      exp_idx  = 0;
    int                      n_iss    = 0;
    int                      n_acc    = 0;
    int                      last_cnt = 0;
    logic                    p_stall  = 1'b0;
    logic signed [WIDTH-1:0] p_re, p_im;
    logic [AW-1:0]           p_idx;
    logic                    p_last;

    always @(negedge clk) begin
        if (rst) begin
            p_stall = 1'b0;
        end else begin
            if (rd_en) begin
                chk("rd_gate_room", longint'((n_iss - n_acc) < FIFO_DEPTH), 1);
                chk("rd_addr_order", bin_addr, n_iss);
                n_iss++;
            end
            if (p_stall) begin
                chk("hold_valid", valid, 1);
                chk("hold_re", re, p_re);
                chk("hold_im", im, p_im);
                chk("hold_idx", idx, p_idx);
                chk("hold_last", last, p_last);
`ifdef DFT_BIN_MAGSQ_EN
                chk("hold_magsq", magsq, p_mag);
`endif
            end
            if (valid) begin
                chk("beat_in_frame", longint'(exp_idx < BIN_NUM), 1);
                if (exp_idx < BIN_NUM) begin
                    chk("beat_idx", idx, exp_idx);
                    chk("beat_re", re, mem_re[exp_idx]);
                    chk("beat_im", im, mem_im[exp_idx]);
                    chk("beat_last", last, longint'(exp_idx == BIN_NUM-1));
`ifdef DFT_BIN_MAGSQ_EN
                    chk("beat_magsq", magsq, exp_magsq(mem_re[exp_idx], mem_im[exp_idx]));
`endif
                    if (ready) begin
                        got_re[exp_idx] = re;
                        got_im[exp_idx] = im;
`ifdef DFT_BIN_MAGSQ_EN
                        got_mag[exp_idx] = magsq;
`endif
                        if (last) last_cnt++;
                        exp_idx++;
                        n_acc++;
                    end
                end
            end
            p_stall = valid & ~ready;
            p_re    = re;
            p_im    = im;
            p_idx   = idx;
            p_last  = last;
`ifdef DFT_BIN_MAGSQ_EN
            p_mag   = magsq;
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        exp_idx  = 0;
        n_iss    = 0;
        n_acc    = 0;
        last_cnt = 0;
    endtask

    task automatic start_frame();
        clear_model();
        done = 1'b1;
        tick();
        done = 1'b0;
    endtask

    task automatic frame_checks(input string tag, input int n, input int max_cyc);
        chk({tag, "_completes"}, longint'(n < max_cyc), 1);
        chk({tag, "_beats"}, exp_idx, BIN_NUM);
        chk({tag, "_last_once"}, last_cnt, 1);
    endtask

    task automatic wait_frame(input string tag, input int max_cyc);
        int n;
        n = 0;
        while ((busy || exp_idx < BIN_NUM) && n < max_cyc) begin
            tick();
            n++;
        end
        frame_checks(tag, n, max_cyc);
    endtask

    task automatic fill(input int mode);
        for (int k = 0; k < BIN_NUM; k++) begin
            case (mode)
                0:       begin mem_re[k] = k;                   mem_im[k] = -k;          end
                1:       begin mem_re[k] = 7*k - 400;           mem_im[k] = 300 - 5*k;   end
                default: begin mem_re[k] = (k*37) % 2048 - 1000; mem_im[k] = 700 - 11*k; end
            endcase
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1);
    end

    initial begin
        int n;
        fill(0);
        ready = 1'b1;
        repeat (3) tick();
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_addr", bin_addr, 0);
        chk("rst_re", re, 0);
        chk("rst_idx", idx, 0);
        chk("rst_last", last, 0);
        rst = 1'b0;
        tick();

        // Free-run: first read right after the sampling edge, first beat two edges later.
        start_frame();
        chk("lat_rd_en", rd_en, 1);
        chk("lat_addr", bin_addr, 0);
        chk("lat_valid_e0", valid, 0);
        tick();
        chk("lat_valid_e1", valid, 0);
        tick();
        chk("lat_valid_e2", valid, 1);
        chk("lat_idx0", idx, 0);
        n = 2;
        while (busy && n < 1000) begin
            tick();
            n++;
        end
        chk("free_frame_len", n, BIN_NUM + 3);
        frame_checks("free", n, 1000);
        chk("free_re5", got_re[5], 5);
        chk("free_im5", got_im[5], -5);
        chk("free_re127", got_re[127], 127);
        chk("free_im127", got_im[127], -127);

        // Backpressure: ready high one cycle in four.
        fill(1);
        start_frame();
        n = 0;
        while ((busy || exp_idx < BIN_NUM) && n < 2000) begin
            ready = (n % 4 == 0);
            tick();
            n++;
        end
        ready = 1'b1;
        frame_checks("bp", n, 2000);
        chk("bp_re0", got_re[0], -400);
        chk("bp_im100", got_im[100], -200);

        // Stall then release.
        fill(2);
        ready = 1'b0;
        start_frame();
        repeat (20) tick();
        chk("stall_rd_en", rd_en, 0);
        chk("stall_issued", n_iss, FIFO_DEPTH);
        chk("stall_valid", valid, 1);
        chk("stall_idx", idx, 0);
        ready = 1'b1;
        n = 0;
        while (exp_idx < BIN_NUM && n < 400) begin
            tick();
            n++;
        end
        chk("release_gapless", n, BIN_NUM);
        wait_frame("release", 50);

        // Overrun: second done edge mid-frame is ignored but flagged.
        fill(0);
        start_frame();
        n = 0;
        while (exp_idx < 50 && n < 200) begin
            tick();
            n++;
        end
        chk("ovr_before", overrun, 0);
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        chk("ovr_set", overrun, 1);
        chk("ovr_busy", busy, 1);
        wait_frame("ovr", 400);
        start_frame();
        wait_frame("ovr_next", 400);
        chk("ovr_sticky", overrun, 1);

        // Reset mid-frame aborts and clears the sticky flag.
        fill(1);
        start_frame();
        n = 0;
        while (exp_idx < 30 && n < 200) begin
            tick();
            n++;
        end
        rst = 1'b1;
        tick();
        clear_model();
        rst = 1'b0;
        chk("mrst_valid", valid, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_overrun", overrun, 0);
        chk("mrst_rd_en", rd_en, 0);
        tick();
        start_frame();
        wait_frame("mrst_next", 400);

        // done held high: only its rising edge starts a frame.
        fill(0);
        clear_model();
        done = 1'b1;
        tick();
        wait_frame("held", 400);
        repeat (5) tick();
        chk("held_no_restart", busy, 0);
        chk("held_reads", n_iss, BIN_NUM);
        done = 1'b0;
        tick();

`ifdef DFT_BIN_MAGSQ_EN
        mem_re[0] = 3;     mem_im[0] = 4;
        mem_re[1] = -2048; mem_im[1] = -2048;
        mem_re[2] = 0;     mem_im[2] = 0;
        start_frame();
        wait_frame("mag", 400);
        chk("magsq_3_4", got_mag[0], 25);
        chk("magsq_min_sat", got_mag[1], 64'hFFFFFF);
        chk("magsq_zero", got_mag[2], 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
